// File: rtl/neuron_controller.sv
// neuron_controller: sequencer for a two-layer neuron datapath.
// For every neuron it clears the accumulator, runs N load/MAC cycles
// with offset 0..N-1, then presents the result through a valid/ready
// handshake. It visits H hidden neurons first and then O output neurons.
// Optional feature macro: NEURON_CTRL_CYCCNT_EN adds a 16-bit saturating
// busy-cycle counter on output cyc_count.
module neuron_controller #(
  parameter int N = 10,
  parameter int H = 4,
  parameter int O = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               res_ready,
  output logic [$clog2(N)-1:0]               offset,
  output logic                               acc_clr,
  output logic                               ld,
  output logic                               ready,
  output logic                               hidden,
  output logic [$clog2((H > O) ? H : O)-1:0] neuron_idx,
  output logic                               res_valid,
  output logic                               busy,
  output logic                               done
`ifdef NEURON_CTRL_CYCCNT_EN
  ,
  output logic [15:0]                        cyc_count
`endif
);

  localparam int OW = $clog2(N);
  localparam int IW = $clog2((H > O) ? H : O);
  localparam logic [OW-1:0] OFF_LAST = OW'(N - 1);
  localparam logic [IW-1:0] H_LAST   = IW'(H - 1);
  localparam logic [IW-1:0] O_LAST   = IW'(O - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    ACT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [OW-1:0]   offset_reg, offset_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            hidden_reg, hidden_next;

  // State and index registers; reset forces IDLE with all indices cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      offset_reg <= '0;
      idx_reg    <= '0;
      hidden_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      idx_reg    <= idx_next;
      hidden_reg <= hidden_next;
    end
  end

  // Next-state and Moore control outputs; one control strobe per state.
  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    idx_next    = idx_reg;
    hidden_next = hidden_reg;
    acc_clr     = 1'b0;
    ld          = 1'b0;
    ready       = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next  = CLEAR;
          hidden_next = 1'b1;
          idx_next    = '0;
          offset_next = '0;
        end
      end
      CLEAR: begin
        acc_clr    = 1'b1;
        state_next = MAC;
      end
      MAC: begin
        ld = 1'b1;
        if (offset_reg == OFF_LAST) begin
          // Offset stays at N-1 through ACT so the datapath view is stable.
          state_next = ACT;
        end else begin
          offset_next = offset_reg + OW'(1);
        end
      end
      ACT: begin
        ready     = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          offset_next = '0;
          if (hidden_reg && (idx_reg == H_LAST)) begin
            hidden_next = 1'b0;
            idx_next    = '0;
            state_next  = CLEAR;
          end else if (!hidden_reg && (idx_reg == O_LAST)) begin
            // Leave indices at zero so IDLE presents inactive outputs.
            idx_next   = '0;
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + IW'(1);
            state_next = CLEAR;
          end
        end
      end
      DONE: begin
        // start is not looked at here, so a start coinciding with done is dropped.
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign offset     = offset_reg;
  assign neuron_idx = idx_reg;
  assign hidden     = hidden_reg;

`ifdef NEURON_CTRL_CYCCNT_EN
  logic [15:0] cyc_count_reg;

  // Busy-cycle counter: cleared on start accept, saturating, frozen in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_count_reg <= 16'd0;
    end else if ((state_reg == IDLE) && start) begin
      cyc_count_reg <= 16'd0;
    end else if ((state_reg != IDLE) && (cyc_count_reg != 16'hFFFF)) begin
      cyc_count_reg <= cyc_count_reg + 16'd1;
    end
  end

  assign cyc_count = cyc_count_reg;
`endif

endmodule

// File: doc/neuron_controller.md
NEURON_CONTROLLER -- requirements
Module: neuron_controller

Interface
REQ-001 SHALL have parameter N, default 10, meaning inputs per neuron (N>=2).
REQ-002 SHALL have parameter H, default 4, meaning hidden-layer neuron count (H>=2).
REQ-003 SHALL have parameter O, default 2, meaning output-layer neuron count (O>=2).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning request one full two-layer evaluation.
REQ-007 SHALL have port res_ready, input, 1, meaning the consumer accepts the current neuron result.
REQ-008 SHALL have port offset, output, $clog2(N), meaning the datapath input/weight select index.
REQ-009 SHALL have port acc_clr, output, 1, meaning clear the datapath accumulator.
REQ-010 SHALL have port ld, output, 1, meaning the datapath accumulator load enable.
REQ-011 SHALL have port ready, output, 1, meaning the activation output is valid.
REQ-012 SHALL have port hidden, output, 1, meaning the hidden-layer scaling select (1 = hidden layer).
REQ-013 SHALL have port neuron_idx, output, $clog2(max(H,O)), meaning the current neuron within the layer.
REQ-014 SHALL have port res_valid, output, 1, meaning the result handshake valid.
REQ-015 SHALL have port busy, output, 1, meaning an evaluation is in progress.
REQ-016 SHALL have port done, output, 1, meaning a one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, MAC, ACT and DONE.
REQ-018 IDLE: outputs inactive; start=1 SHALL transition to CLEAR with hidden=1 and neuron_idx=0.
REQ-019 CLEAR: acc_clr=1 for exactly one cycle, offset=0, then SHALL go to MAC.
REQ-020 MAC: ld=1 for exactly N consecutive cycles, offset 0,1,...,N-1, one per cycle, then SHALL go to ACT.
REQ-021 ACT: ready=1 and res_valid=1 SHALL be held, with ld=0 and offset, hidden and neuron_idx stable, until res_valid&&res_ready.
REQ-022 On accept in ACT with a non-last neuron, the block SHALL increment neuron_idx and go to CLEAR.
REQ-023 On accept of neuron H-1 with hidden=1, the block SHALL clear hidden, set neuron_idx=0 and go to CLEAR.
REQ-024 On accept of neuron O-1 with hidden=0, the block SHALL go to DONE.
REQ-025 DONE: done=1 for one cycle, then SHALL go to IDLE; done and start in the same cycle SHALL NOT restart.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start SHALL be ignored while busy=1; it is level-sampled in IDLE only.
REQ-028 With res_ready tied high, each neuron SHALL take N+2 cycles, and done SHALL assert (H+O)*(N+2)+1 cycles after the start-sampling edge (73 at defaults).
REQ-029 acc_clr, ld and ready SHALL be mutually exclusive in every cycle.
REQ-030 offset SHALL never exceed N-1, and neuron_idx SHALL never exceed (hidden ? H-1 : O-1).

Reset
REQ-031 rst=0 SHALL force IDLE immediately, regardless of the clock.
REQ-032 During reset, all outputs SHALL be 0: offset=0, neuron_idx=0, hidden=0, acc_clr=0, ld=0, ready=0, res_valid=0, busy=0, done=0.
REQ-033 Reset mid-operation SHALL abandon the evaluation without emitting done; the first start after release SHALL begin at hidden neuron 0.

Configuration
REQ-034 With NEURON_CTRL_CYCCNT_EN defined, the block SHALL add output cyc_count, 16 bits.
REQ-035 cyc_count SHALL clear on the start-accept edge, increment in every busy cycle, saturate at 16'hFFFF, hold in IDLE, and reset to 0.
REQ-036 Without NEURON_CTRL_CYCCNT_EN, neither the port nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-037 Defaults, start pulse, res_ready=1 -> 6 res_valid handshakes: hidden=1 for idx 0..3, then hidden=0 for idx 0..1; done 73 cycles after start; cyc_count=73 if enabled.
REQ-038 During each MAC phase -> ld=1 for exactly 10 cycles with offset 0..9, preceded by one acc_clr cycle.
REQ-039 res_ready held low 5 cycles at hidden neuron 2 -> ready, res_valid and neuron_idx=2 stable for 5 cycles; done delayed by exactly 5 cycles (78).
REQ-040 start pulsed again at cycle 20 of a run -> no effect; exactly 6 handshakes and one done.
REQ-041 rst=0 asserted mid-MAC of output neuron 1 -> all outputs 0 asynchronously, no done; restart -> full 73-cycle run from hidden neuron 0.
REQ-042 Every cycle of every run -> assertion that at most one of acc_clr, ld, ready is 1, and offset<=9.
